// File: rtl/dual_issue_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dual_issue_ctrl_pkg
// Shared definitions for the dual-issue scheduler:
//   - RV32 major opcode constants (the InstrGenPkg subset the scheduler needs)
//   - hazard_signal_t : hazard tag handed to the forwarding mux
//   - issue_state_e   : scheduler FSM states
//   - helpers classifying opcodes and detecting load-use matches
// -----------------------------------------------------------------------------
package dual_issue_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_IMME = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_S_TYPE = 7'b0100011;
  localparam logic [6:0] OP_B_TYPE = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    NONE_h  = 2'd0,
    A_STALL = 2'd1,
    B_STALL = 2'd2,
    HOLD_B  = 2'd3
  } hazard_signal_t;

  typedef enum logic [1:0] {
    ST_ISSUE  = 2'd0,
    ST_HOLD_B = 2'd1,
    ST_STALL  = 2'd2
  } issue_state_e;

  // Opcodes that write rd.
  function automatic logic is_writer(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I_IMME) || (op == OP_LOAD) || (op == OP_JAL) ||
           (op == OP_JALR) || (op == OP_LUI) || (op == OP_AUIPC);
  endfunction

  // Instructions needing the single data-memory port.
  function automatic logic is_mem(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_S_TYPE);
  endfunction

  // Control transfers: the slot after them must not issue in the same cycle.
  function automatic logic is_ctrl(input logic [6:0] op);
    return (op == OP_B_TYPE) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

  // A LOAD producing rd (non-zero) that feeds either source.
  function automatic logic load_hit(input logic [6:0] op, input logic [4:0] rd,
                                    input logic [4:0] rs1, input logic [4:0] rs2);
    return (op == OP_LOAD) && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/dual_issue_ctrl_issue_hazard_chk.sv
// -----------------------------------------------------------------------------
// issue_hazard_chk
// Purely combinational hazard detection for the dual-issue scheduler.
// Ports:
//   i_hold_b             scheduler is issuing the held-back lane B only
//   i_ida_* / i_idb_*    lane A / lane B instruction fields in ID
//   i_idex*_op/_rd       instructions currently in the ID/EX lanes
//   o_lu_a / o_lu_b      load-use hit against ID/EX lane A / lane B
//   o_split              pair cannot issue together (only meaningful in ST_ISSUE)
// -----------------------------------------------------------------------------
module issue_hazard_chk
  import dual_issue_ctrl_pkg::*;
(
  input  logic       i_hold_b,
  input  logic [6:0] i_ida_op,
  input  logic [4:0] i_ida_rd,
  input  logic [4:0] i_ida_rs1,
  input  logic [4:0] i_ida_rs2,
  input  logic [6:0] i_idb_op,
  input  logic [4:0] i_idb_rs1,
  input  logic [4:0] i_idb_rs2,
  input  logic [6:0] i_idexa_op,
  input  logic [4:0] i_idexa_rd,
  input  logic [6:0] i_idexb_op,
  input  logic [4:0] i_idexb_rd,
  output logic       o_lu_a,
  output logic       o_lu_b,
  output logic       o_split
);

  logic w_xa_a, w_xa_b, w_xb_a, w_xb_b;

  assign w_xa_a = load_hit(i_idexa_op, i_idexa_rd, i_ida_rs1, i_ida_rs2);
  assign w_xa_b = load_hit(i_idexa_op, i_idexa_rd, i_idb_rs1, i_idb_rs2);
  assign w_xb_a = load_hit(i_idexb_op, i_idexb_rd, i_ida_rs1, i_ida_rs2);
  assign w_xb_b = load_hit(i_idexb_op, i_idexb_rd, i_idb_rs1, i_idb_rs2);

  // Lane A has already issued while holding B, so its sources no longer matter.
  assign o_lu_a = w_xa_b | (~i_hold_b & w_xa_a);
  assign o_lu_b = w_xb_b | (~i_hold_b & w_xb_a);

  // Only a load result cannot reach B in time; ALU results forward from A.
  assign o_split = load_hit(i_ida_op, i_ida_rd, i_idb_rs1, i_idb_rs2) |
                   (is_mem(i_ida_op) & is_mem(i_idb_op)) |
                   is_ctrl(i_ida_op);

endmodule

// File: rtl/dual_issue_ctrl.sv
// -----------------------------------------------------------------------------
// dual_issue_ctrl
// Issue scheduler for the two-lane in-order pipeline (between IF/ID and ID/EX).
// Decides per cycle: dual issue, lane A alone, lane B alone (held pair), or
// no issue (load-use stall, redirect flush, invalid fetch).
// Optional feature macro: PERF_CNT_EN enables saturating perf counters;
// without it the counter ports read 0 and no counter flops exist.
// Ports:
//   i_clk, i_rst_n          clock, async active-low reset
//   i_if_valid              IF/ID holds a valid pair
//   i_id{a,b}_*             ID lane opcodes / rd / sources
//   i_idex{a,b}_op/_rd      ID/EX lane opcodes / rd
//   i_ex_redirect           taken branch/jump resolved in EX
//   o_issue_a/_b            load ID/EX lane A / B
//   o_ifid_hold             freeze IF/ID
//   o_flush                 clear IF/ID and ID/EX
//   o_pc_inc                instructions consumed (0..2)
//   o_haz_tag               hazard_signal_t encoding for the forwarding mux
//   o_cnt_dual/_single/_stall  perf counters
//
// state     | meaning
// ST_ISSUE  | normal: pair may issue together
// ST_HOLD_B | lane A issued alone, lane B waits in IF/ID
// ST_STALL  | extra load-use bubbles, returns to r_ret_state
// -----------------------------------------------------------------------------
module dual_issue_ctrl
  import dual_issue_ctrl_pkg::*;
#(
  parameter int LOAD_USE_CYCLES = 1,
  parameter int CNT_W           = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_if_valid,
  input  logic [6:0]       i_ida_op,
  input  logic [6:0]       i_idb_op,
  input  logic [4:0]       i_ida_rd,
  input  logic [4:0]       i_idb_rd,
  input  logic [4:0]       i_ida_rs1,
  input  logic [4:0]       i_ida_rs2,
  input  logic [4:0]       i_idb_rs1,
  input  logic [4:0]       i_idb_rs2,
  input  logic [6:0]       i_idexa_op,
  input  logic [6:0]       i_idexb_op,
  input  logic [4:0]       i_idexa_rd,
  input  logic [4:0]       i_idexb_rd,
  input  logic             i_ex_redirect,
  output logic             o_issue_a,
  output logic             o_issue_b,
  output logic             o_ifid_hold,
  output logic             o_flush,
  output logic [1:0]       o_pc_inc,
  output logic [1:0]       o_haz_tag,
  output logic [CNT_W-1:0] o_cnt_dual,
  output logic [CNT_W-1:0] o_cnt_single,
  output logic [CNT_W-1:0] o_cnt_stall
);

  localparam logic [2:0] LU_RELOAD = 3'(LOAD_USE_CYCLES - 1);

  issue_state_e   r_state, w_state_nxt;
  issue_state_e   r_ret_state, w_ret_nxt;
  logic [2:0]     r_cnt, w_cnt_nxt;
  logic           w_lu_a, w_lu_b, w_lu, w_split;
  hazard_signal_t w_haz;
  logic           w_unused_idb_rd;

  // B's destination never gates issue; nothing younger in the pair reads it.
  assign w_unused_idb_rd = ^i_idb_rd;

  issue_hazard_chk u_haz (
    .i_hold_b   (r_state == ST_HOLD_B),
    .i_ida_op   (i_ida_op),
    .i_ida_rd   (i_ida_rd),
    .i_ida_rs1  (i_ida_rs1),
    .i_ida_rs2  (i_ida_rs2),
    .i_idb_op   (i_idb_op),
    .i_idb_rs1  (i_idb_rs1),
    .i_idb_rs2  (i_idb_rs2),
    .i_idexa_op (i_idexa_op),
    .i_idexa_rd (i_idexa_rd),
    .i_idexb_op (i_idexb_op),
    .i_idexb_rd (i_idexb_rd),
    .o_lu_a     (w_lu_a),
    .o_lu_b     (w_lu_b),
    .o_split    (w_split)
  );

  assign w_lu = w_lu_a | w_lu_b;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_ISSUE;
      r_ret_state <= ST_ISSUE;
      r_cnt       <= 3'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_ret_state <= w_ret_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ret_nxt   = r_ret_state;
    w_cnt_nxt   = r_cnt;
    if (i_ex_redirect) begin
      w_state_nxt = ST_ISSUE;
      w_cnt_nxt   = 3'd0;
    end else if (r_state == ST_STALL) begin
      if (r_cnt <= 3'd1) begin
        w_state_nxt = r_ret_state;
        w_cnt_nxt   = 3'd0;
      end else begin
        w_cnt_nxt = r_cnt - 3'd1;
      end
    end else if (!i_if_valid) begin
      w_state_nxt = r_state;
    end else if (w_lu) begin
      // A single bubble needs no stall state: the same check simply re-runs.
      if (LOAD_USE_CYCLES > 1) begin
        w_ret_nxt   = r_state;
        w_cnt_nxt   = LU_RELOAD;
        w_state_nxt = ST_STALL;
      end
    end else if (r_state == ST_ISSUE && w_split) begin
      w_state_nxt = ST_HOLD_B;
    end else if (r_state == ST_HOLD_B) begin
      w_state_nxt = ST_ISSUE;
    end
  end

  always_comb begin
    o_issue_a   = 1'b0;
    o_issue_b   = 1'b0;
    o_ifid_hold = 1'b0;
    o_flush     = 1'b0;
    o_pc_inc    = 2'd0;
    w_haz       = NONE_h;
    if (!i_rst_n) begin
      // outputs forced quiet while reset is held
      w_haz = NONE_h;
    end else if (i_ex_redirect) begin
      o_flush = 1'b1;
    end else if (r_state == ST_STALL) begin
      o_ifid_hold = 1'b1;
    end else if (!i_if_valid) begin
      w_haz = NONE_h;
    end else if (w_lu) begin
      o_ifid_hold = 1'b1;
      w_haz       = w_lu_a ? A_STALL : B_STALL;
    end else if (r_state == ST_ISSUE && w_split) begin
      o_issue_a   = 1'b1;
      o_ifid_hold = 1'b1;
      o_pc_inc    = 2'd1;
      w_haz       = HOLD_B;
    end else if (r_state == ST_HOLD_B) begin
      o_issue_b = 1'b1;
      o_pc_inc  = 2'd1;
    end else begin
      o_issue_a = 1'b1;
      o_issue_b = 1'b1;
      o_pc_inc  = 2'd2;
    end
  end

  assign o_haz_tag = w_haz;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] r_cnt_dual, r_cnt_single, r_cnt_stall;
  logic             w_dual, w_single, w_stall_cyc;

  assign w_dual      = o_issue_a & o_issue_b;
  assign w_single    = o_issue_a ^ o_issue_b;
  assign w_stall_cyc = i_if_valid & ~o_issue_a & ~o_issue_b;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt_dual   <= '0;
      r_cnt_single <= '0;
      r_cnt_stall  <= '0;
    end else begin
      if (w_dual && r_cnt_dual != '1)        r_cnt_dual   <= r_cnt_dual + CNT_W'(1);
      if (w_single && r_cnt_single != '1)    r_cnt_single <= r_cnt_single + CNT_W'(1);
      if (w_stall_cyc && r_cnt_stall != '1)  r_cnt_stall  <= r_cnt_stall + CNT_W'(1);
    end
  end

  assign o_cnt_dual   = r_cnt_dual;
  assign o_cnt_single = r_cnt_single;
  assign o_cnt_stall  = r_cnt_stall;
`else
  assign o_cnt_dual   = '0;
  assign o_cnt_single = '0;
  assign o_cnt_stall  = '0;
`endif

endmodule

// File: tb/tb_dual_issue_ctrl.sv
module tb_dual_issue_ctrl;
  import dual_issue_ctrl_pkg::*;

  localparam int LUC   = 3;
  localparam int CNT_W = 4;

  logic             clk, rst_n, if_valid, ex_redirect;
  logic [6:0]       ida_op, idb_op, idexa_op, idexb_op;
  logic [4:0]       ida_rd, idb_rd, ida_rs1, ida_rs2, idb_rs1, idb_rs2, idexa_rd, idexb_rd;
  logic             issue_a, issue_b, ifid_hold, flush;
  logic [1:0]       pc_inc, haz_tag;
  logic [CNT_W-1:0] cnt_dual, cnt_single, cnt_stall;

  dual_issue_ctrl #(.LOAD_USE_CYCLES(LUC), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_if_valid(if_valid),
    .i_ida_op(ida_op), .i_idb_op(idb_op), .i_ida_rd(ida_rd), .i_idb_rd(idb_rd),
    .i_ida_rs1(ida_rs1), .i_ida_rs2(ida_rs2), .i_idb_rs1(idb_rs1), .i_idb_rs2(idb_rs2),
    .i_idexa_op(idexa_op), .i_idexb_op(idexb_op), .i_idexa_rd(idexa_rd), .i_idexb_rd(idexb_rd),
    .i_ex_redirect(ex_redirect),
    .o_issue_a(issue_a), .o_issue_b(issue_b), .o_ifid_hold(ifid_hold), .o_flush(flush),
    .o_pc_inc(pc_inc), .o_haz_tag(haz_tag),
    .o_cnt_dual(cnt_dual), .o_cnt_single(cnt_single), .o_cnt_stall(cnt_stall)
  );

  typedef struct {
    bit rst, valid, redir;
    logic [6:0] aop, bop, xaop, xbop;
    logic [4:0] ard, ars1, ars2, brd, brs1, brs2, xard, xbrd;
  } stim_t;

  typedef struct {
    logic ia, ib, hold, flush;
    logic [1:0] pc, tag;
    logic [CNT_W-1:0] cd, cs, ct;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // reference model: pending-B flag, remaining bubbles, raw event counts
  bit m_b_pend;
  int m_stall_left, m_dual, m_single, m_stall;

  localparam logic [6:0] OPS [10] = '{OP_R, OP_I_IMME, OP_LOAD, OP_LOAD, OP_S_TYPE,
                                      OP_B_TYPE, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic int sat(input int v);
    return (v < (1 << CNT_W) - 1) ? v + 1 : v;
  endfunction

  function automatic stim_t pair(input logic [6:0] aop, input int ard, input int ars1, input int ars2,
                                 input logic [6:0] bop, input int brd, input int brs1, input int brs2);
    stim_t s;
    s.rst = 1; s.valid = 1; s.redir = 0;
    s.aop = aop; s.ard = 5'(ard); s.ars1 = 5'(ars1); s.ars2 = 5'(ars2);
    s.bop = bop; s.brd = 5'(brd); s.brs1 = 5'(brs1); s.brs2 = 5'(brs2);
    s.xaop = OP_I_IMME; s.xard = 5'd0; s.xbop = OP_I_IMME; s.xbrd = 5'd0;
    return s;
  endfunction

  task automatic model(input stim_t s);
    exp_t e;
    logic [4:0] srcs[$];
    bit hit_a, hit_b, split;
    e.ia = 0; e.ib = 0; e.hold = 0; e.flush = 0; e.pc = 2'd0; e.tag = NONE_h;
`ifdef PERF_CNT_EN
    e.cd = CNT_W'(m_dual); e.cs = CNT_W'(m_single); e.ct = CNT_W'(m_stall);
`else
    e.cd = '0; e.cs = '0; e.ct = '0;
`endif
    if (!s.rst) begin
      m_b_pend = 0; m_stall_left = 0; m_dual = 0; m_single = 0; m_stall = 0;
      e.cd = '0; e.cs = '0; e.ct = '0;
    end else begin
      if (s.redir) begin
        e.flush = 1; m_stall_left = 0; m_b_pend = 0;
      end else if (m_stall_left > 0) begin
        e.hold = 1; m_stall_left--;
      end else if (s.valid) begin
        srcs = {};
        if (!m_b_pend) begin srcs.push_back(s.ars1); srcs.push_back(s.ars2); end
        srcs.push_back(s.brs1); srcs.push_back(s.brs2);
        hit_a = 0; hit_b = 0;
        foreach (srcs[i]) begin
          if (s.xaop == OP_LOAD && s.xard != 0 && s.xard == srcs[i]) hit_a = 1;
          if (s.xbop == OP_LOAD && s.xbrd != 0 && s.xbrd == srcs[i]) hit_b = 1;
        end
        split = (s.aop == OP_LOAD && s.ard != 0 && (s.ard == s.brs1 || s.ard == s.brs2)) ||
                ((s.aop inside {OP_LOAD, OP_S_TYPE}) && (s.bop inside {OP_LOAD, OP_S_TYPE})) ||
                (s.aop inside {OP_B_TYPE, OP_JAL, OP_JALR});
        if (hit_a || hit_b) begin
          e.hold = 1; e.tag = hit_a ? A_STALL : B_STALL; m_stall_left = LUC - 1;
        end else if (!m_b_pend && split) begin
          e.ia = 1; e.hold = 1; e.pc = 2'd1; e.tag = HOLD_B; m_b_pend = 1;
        end else if (m_b_pend) begin
          e.ib = 1; e.pc = 2'd1; m_b_pend = 0;
        end else begin
          e.ia = 1; e.ib = 1; e.pc = 2'd2;
        end
      end
      if (e.ia && e.ib) m_dual = sat(m_dual);
      else if (e.ia || e.ib) m_single = sat(m_single);
      else if (s.valid) m_stall = sat(m_stall);
    end
    exp_q.push_back(e);
  endtask

  task automatic drive(input stim_t s);
    @(posedge clk);
    #2;
    rst_n = s.rst; if_valid = s.valid; ex_redirect = s.redir;
    ida_op = s.aop; ida_rd = s.ard; ida_rs1 = s.ars1; ida_rs2 = s.ars2;
    idb_op = s.bop; idb_rd = s.brd; idb_rs1 = s.brs1; idb_rs2 = s.brs2;
    idexa_op = s.xaop; idexa_rd = s.xard; idexb_op = s.xbop; idexb_rd = s.xbrd;
    model(s);
  endtask

  // monitor: one output set per cycle, sampled mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({issue_a, issue_b, ifid_hold, flush, pc_inc, haz_tag, cnt_dual, cnt_single, cnt_stall} !==
            {e.ia, e.ib, e.hold, e.flush, e.pc, e.tag, e.cd, e.cs, e.ct}) begin
          n_fail++;
          $display("FAIL outputs cyc %0d: got ia=%0b ib=%0b hold=%0b flush=%0b pc=%0d tag=%0d cd=%0d cs=%0d ct=%0d | want ia=%0b ib=%0b hold=%0b flush=%0b pc=%0d tag=%0d cd=%0d cs=%0d ct=%0d",
                   cyc, issue_a, issue_b, ifid_hold, flush, pc_inc, haz_tag, cnt_dual, cnt_single, cnt_stall,
                   e.ia, e.ib, e.hold, e.flush, e.pc, e.tag, e.cd, e.cs, e.ct);
        end
      end
    end
  end

  initial begin
    stim_t s;
    rst_n = 0; if_valid = 0; ex_redirect = 0;
    ida_op = '0; idb_op = '0; idexa_op = '0; idexb_op = '0;
    ida_rd = '0; idb_rd = '0; ida_rs1 = '0; ida_rs2 = '0; idb_rs1 = '0; idb_rs2 = '0;
    idexa_rd = '0; idexb_rd = '0;
    m_b_pend = 0; m_stall_left = 0; m_dual = 0; m_single = 0; m_stall = 0;

    // reset held with a live pair presented
    s = pair(OP_R, 5, 1, 2, OP_R, 6, 3, 4); s.rst = 0;
    drive(s); drive(s);
    // plain dual issue
    drive(pair(OP_R, 5, 1, 2, OP_R, 6, 3, 4));
    // load-use on lane A against ID/EX lane A, then the pair issues
    s = pair(OP_R, 8, 7, 1, OP_R, 11, 3, 4); s.xaop = OP_LOAD; s.xard = 5'd7;
    repeat (LUC) drive(s);
    s.xaop = OP_I_IMME; s.xard = 5'd0; drive(s);
    // LOAD feeding B in the same pair: split, stall B, then B alone
    s = pair(OP_LOAD, 9, 1, 0, OP_R, 10, 9, 2); drive(s);
    s.xaop = OP_LOAD; s.xard = 5'd9; repeat (LUC) drive(s);
    s.xaop = OP_I_IMME; s.xard = 5'd0; drive(s);
    // two memory ops share one port
    s = pair(OP_S_TYPE, 0, 1, 2, OP_LOAD, 12, 3, 0); drive(s); drive(s);
    // redirect in the middle of a stall leaves no residue
    s = pair(OP_R, 8, 7, 1, OP_R, 6, 3, 4); s.xbop = OP_LOAD; s.xbrd = 5'd7;
    drive(s); drive(s);
    s.redir = 1; drive(s);
    s.redir = 0; s.xbop = OP_I_IMME; s.xbrd = 5'd0; drive(s);
    // rd==0 load never stalls
    s = pair(OP_R, 8, 0, 0, OP_R, 6, 0, 0); s.xaop = OP_LOAD; drive(s);
    // reset while holding B
    s = pair(OP_JAL, 1, 0, 0, OP_R, 2, 3, 4); drive(s);
    s.rst = 0; drive(s);
    drive(pair(OP_R, 5, 1, 2, OP_R, 6, 3, 4));

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      s = pair(OPS[$urandom_range(0, 9)], $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               OPS[$urandom_range(0, 9)], $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      s.xaop  = OPS[$urandom_range(0, 9)];
      s.xard  = 5'($urandom_range(0, 3));
      s.xbop  = OPS[$urandom_range(0, 9)];
      s.xbrd  = 5'($urandom_range(0, 3));
      s.valid = ($urandom_range(0, 7) != 0);
      s.redir = ($urandom_range(0, 11) == 0);
      s.rst   = ($urandom_range(0, 149) != 0);
      drive(s);
    end

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
